// File: rtl/interrupter_gen.sv
// Burst interrupter: turns period / on-time / pulse-count / gap parameters into
// the bridge enable, its predictive lead-in and the bridge-half select.
module interrupter_gen #(
    parameter int W         = 16,
    parameter int NW        = 8,
    parameter int PRED_LEAD = 4,
    parameter int TICK_DIV  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          cfg_valid,
    input  logic [W-1:0]  cfg_period,
    input  logic [W-1:0]  cfg_ton,
    input  logic [NW-1:0] cfg_pulses,
    input  logic [W-1:0]  cfg_gap,
    output logic          cfg_ready,
    output logic          busy,
    output logic          out,
    output logic          out_pred,
    output logic          sel,
    output logic [2:0]    dbg_state
);

    // Handshake: cfg_valid is a one-cycle write strobe; a write is accepted on
    // any edge where cfg_ready is high, and cfg_ready stays high once out of reset.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_ON   = 3'd2,
        S_OFF  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    localparam logic [W-1:0] LEAD = W'(PRED_LEAD);

    state_t        state, state_n;
    logic [W-1:0]  cnt, cnt_n;
    logic [NW-1:0] rem, rem_n;
    logic          load;
    logic          tick;

    logic [W-1:0]  pend_p, pend_t, pend_g;
    logic [NW-1:0] pend_n;
    logic [W-1:0]  act_p, act_t, act_g;
    logic [NW-1:0] act_n;

    logic [W-1:0]  ld_t;
    logic          ld_ok;

    generate
        if (TICK_DIV > 1) begin : g_div
            localparam int PW = $clog2(TICK_DIV);
            logic [PW-1:0] pre_cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pre_cnt <= '0;
                end else if (pre_cnt == PW'(TICK_DIV - 1)) begin
                    pre_cnt <= '0;
                end else begin
                    pre_cnt <= pre_cnt + 1'b1;
                end
            end
            assign tick = (pre_cnt == PW'(TICK_DIV - 1));
        end else begin : g_nodiv
            assign tick = 1'b1;
        end
    endgenerate

    // On-time is clamped so every pulse keeps at least one low tick.
    assign ld_t  = (pend_t >= pend_p) ? (pend_p - 1'b1) : pend_t;
    assign ld_ok = (pend_p != '0) && (ld_t != '0) && (pend_n != '0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rem_n   = rem;
        load    = 1'b0;
        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        load = 1'b1;
                        if (ld_ok) begin
                            state_n = S_PRE;
                            cnt_n   = LEAD;
                        end
                    end
                end
                S_PRE: begin
                    if (!enable) begin
                        state_n = S_IDLE;
                    end else if (cnt <= 1) begin
                        state_n = S_ON;
                        cnt_n   = act_t;
                        rem_n   = act_n - 1'b1;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                S_ON: begin
                    // A pulse in flight always runs its full on-time.
                    if (cnt <= 1) begin
                        if (!enable) begin
                            state_n = S_IDLE;
                        end else begin
                            state_n = S_OFF;
                            cnt_n   = act_p - act_t;
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                S_OFF: begin
                    if (!enable) begin
                        state_n = S_IDLE;
                    end else if (cnt <= 1) begin
                        if (rem != '0) begin
                            state_n = S_ON;
                            cnt_n   = act_t;
                            rem_n   = rem - 1'b1;
                        end else if (act_g != '0) begin
                            state_n = S_GAP;
                            cnt_n   = act_g;
                        end else begin
                            load    = 1'b1;
                            state_n = ld_ok ? S_PRE : S_IDLE;
                            cnt_n   = LEAD;
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (!enable) begin
                        state_n = S_IDLE;
                    end else if (cnt <= 1) begin
                        load    = 1'b1;
                        state_n = ld_ok ? S_PRE : S_IDLE;
                        cnt_n   = LEAD;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            rem   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rem   <= rem_n;
        end
    end

    // Pending set is written by the parser; active set only changes at a burst load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_p <= '0;
            pend_t <= '0;
            pend_n <= '0;
            pend_g <= '0;
            act_p  <= '0;
            act_t  <= '0;
            act_n  <= '0;
            act_g  <= '0;
        end else begin
            if (cfg_valid && cfg_ready) begin
                pend_p <= cfg_period;
                pend_t <= cfg_ton;
                pend_n <= cfg_pulses;
                pend_g <= cfg_gap;
            end
            if (load) begin
                act_p <= pend_p;
                act_t <= ld_t;
                act_n <= pend_n;
                act_g <= pend_g;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            out       <= 1'b0;
            out_pred  <= 1'b0;
            sel       <= 1'b0;
        end else begin
            cfg_ready <= 1'b1;
            busy      <= (state != S_IDLE);
            out       <= (state == S_ON);
            out_pred  <= (state == S_PRE) ||
                         ((state == S_OFF) && (rem != '0) && (cnt <= LEAD));
            sel       <= sel ^ (out & (state != S_ON));
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_interrupter_gen.sv
// Self-checking bench for interrupter_gen: a pulse-schedule reference model
// plus directed enable/reset/invalid-parameter scenarios.
module tb_interrupter_gen;

    localparam int W      = 16;
    localparam int NW     = 8;
    localparam int PL     = 4;
    localparam int NC_MAX = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [W-1:0]  cfg_period = '0;
    logic [W-1:0]  cfg_ton = '0;
    logic [NW-1:0] cfg_pulses = '0;
    logic [W-1:0]  cfg_gap = '0;
    logic          cfg_ready;
    logic          busy;
    logic          out;
    logic          out_pred;
    logic          sel;
    logic [2:0]    dbg_state;

    int n_checks = 0;
    int n_pass = 0;
    logic [3:0] exp_q[$];

    interrupter_gen #(.W(W), .NW(NW), .PRED_LEAD(PL), .TICK_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_valid(cfg_valid),
        .cfg_period(cfg_period), .cfg_ton(cfg_ton), .cfg_pulses(cfg_pulses),
        .cfg_gap(cfg_gap), .cfg_ready(cfg_ready), .busy(busy), .out(out),
        .out_pred(out_pred), .sel(sel), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic program_cfg(input int p, input int t, input int n, input int g);
        cfg_period = W'(p); cfg_ton = W'(t); cfg_pulses = NW'(n); cfg_gap = W'(g);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Pulse schedule: a burst starting at edge b shows its lead-in on cycles
    // b+1..b+PL, pulse k rises at b+PL+k*P+1, and the next burst starts PL+N*P+G later.
    task automatic build_model(input int nc, input int p0, input int t0, input int n0,
                               input int g0, input int chg, input int p1, input int t1,
                               input int n1, input int g1);
        bit m_out[NC_MAX];
        bit m_pred[NC_MAX];
        bit m_tog[NC_MAX];
        int b, p, t, n, g, r;
        bit s;
        for (int i = 0; i < NC_MAX; i++) begin
            m_out[i] = 0; m_pred[i] = 0; m_tog[i] = 0;
        end
        b = 0;
        while (b < nc) begin
            if (chg >= 0 && chg < b) begin
                p = p1; t = t1; n = n1; g = g1;
            end else begin
                p = p0; t = t0; n = n0; g = g0;
            end
            if (t >= p) t = p - 1;
            if (p == 0 || t == 0 || n == 0) break;
            for (int k = 0; k < n; k++) begin
                r = b + PL + k * p + 1;
                for (int i = 0; i < t; i++)
                    if (r + i < NC_MAX) m_out[r+i] = 1;
                for (int i = 1; i <= PL; i++)
                    if ((k == 0 || i <= p - t) && r - i >= 0 && r - i < NC_MAX)
                        m_pred[r-i] = 1;
                if (r + t < NC_MAX) m_tog[r+t] = 1;
            end
            b += PL + n * p + g;
        end
        exp_q.delete();
        s = 0;
        for (int c = 0; c < nc; c++) begin
            s ^= m_tog[c];
            exp_q.push_back({(c >= 1), s, m_pred[c], m_out[c]});
        end
    endtask

    task automatic run_scenario(input string name, input int nc, input int p0, input int t0,
                                input int n0, input int g0, input int chg, input int p1,
                                input int t1, input int n1, input int g1);
        logic [3:0] got, e;
        do_reset();
        program_cfg(p0, t0, n0, g0);
        build_model(nc, p0, t0, n0, g0, chg, p1, t1, n1, g1);
        for (int c = 0; c < nc; c++) begin
            enable = 1'b1;
            if (c == chg) begin
                cfg_period = W'(p1); cfg_ton = W'(t1); cfg_pulses = NW'(n1); cfg_gap = W'(g1);
                cfg_valid = 1'b1;
            end else begin
                cfg_valid = 1'b0;
            end
            @(posedge clk); #1;
            got = {busy, sel, out_pred, out};
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e)
                $display("FAIL %s cycle %0d busy/sel/pred/out got %b expected %b", name, c, got, e);
            else
                n_pass++;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        enable = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #12;
        n_checks++;
        if ({out, out_pred, sel, busy, cfg_ready} !== 5'b0)
            $display("FAIL reset_outputs got %b expected 00000", {out, out_pred, sel, busy, cfg_ready});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready got %b expected 1", cfg_ready);
        else n_pass++;
        n_checks++;
        if ({out, out_pred, sel, busy} !== 4'b0)
            $display("FAIL reset_idle got %b expected 0000", {out, out_pred, sel, busy});
        else n_pass++;
    endtask

    task automatic test_spec_pattern();
        run_scenario("spec_pattern", 60, 10, 3, 2, 5, -1, 0, 0, 0, 0);
    endtask

    task automatic test_clamp();
        run_scenario("clamp", 80, 10, 12, 3, 2, -1, 0, 0, 0, 0);
    endtask

    task automatic test_cfg_update();
        run_scenario("cfg_mid_burst", 120, 10, 3, 2, 5, 10, 20, 3, 2, 5);
    endtask

    task automatic test_same_edge_load();
        run_scenario("cfg_on_load_edge", 120, 10, 3, 2, 5, 29, 20, 3, 2, 5);
    endtask

    task automatic test_enable_drop_on();
        do_reset();
        program_cfg(10, 3, 2, 5);
        for (int c = 0; c <= 12; c++) begin
            enable = (c < 6);
            @(posedge clk); #1;
            n_checks++;
            if ({out_pred, out} !== {(c >= 1 && c <= 4), (c >= 5 && c <= 7)})
                $display("FAIL drop_on cycle %0d pred/out got %b expected %b", c,
                         {out_pred, out}, {(c >= 1 && c <= 4), (c >= 5 && c <= 7)});
            else n_pass++;
            if (c >= 9) begin
                n_checks++;
                if (busy !== 1'b0) $display("FAIL drop_on_busy cycle %0d got %b expected 0", c, busy);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (sel !== 1'b1) $display("FAIL drop_on_sel_retained got %b expected 1", sel);
        else n_pass++;
    endtask

    task automatic test_enable_drop_pre();
        do_reset();
        program_cfg(10, 3, 2, 5);
        for (int c = 0; c <= 12; c++) begin
            enable = (c < 2);
            @(posedge clk); #1;
            n_checks++;
            if ({out_pred, out} !== {(c == 1 || c == 2), 1'b0})
                $display("FAIL drop_pre cycle %0d pred/out got %b expected %b", c,
                         {out_pred, out}, {(c == 1 || c == 2), 1'b0});
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if ({busy, sel} !== 2'b00) $display("FAIL drop_pre_idle busy/sel got %b expected 00", {busy, sel});
        else n_pass++;
    endtask

    task automatic test_invalid();
        int ps[4] = '{0, 10, 10, 1};
        int ts[4] = '{3, 3, 0, 1};
        int ns[4] = '{2, 0, 2, 2};
        for (int k = 0; k < 4; k++) begin
            do_reset();
            program_cfg(ps[k], ts[k], ns[k], 5);
            for (int c = 0; c < 20; c++) begin
                enable = 1'b1;
                @(posedge clk); #1;
                n_checks++;
                if ({busy, out_pred, out} !== 3'b000)
                    $display("FAIL invalid_%0d cycle %0d busy/pred/out got %b expected 000", k, c,
                             {busy, out_pred, out});
                else n_pass++;
                @(negedge clk);
            end
            enable = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        program_cfg(10, 3, 2, 5);
        for (int c = 0; c < 16; c++) begin
            enable = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({sel, out} !== 2'b11) $display("FAIL reset_mid_pre sel/out got %b expected 11", {sel, out});
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out, out_pred, sel, busy, cfg_ready} !== 5'b0)
            $display("FAIL reset_mid_async got %b expected 00000", {out, out_pred, sel, busy, cfg_ready});
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({out, cfg_ready} !== 2'b00) $display("FAIL reset_mid_held out/cfg_ready got %b expected 00", {out, cfg_ready});
        else n_pass++;
        @(negedge clk);
        enable = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (cfg_ready !== 1'b1) $display("FAIL reset_mid_release cfg_ready got %b expected 1", cfg_ready);
        else n_pass++;
    endtask

    task automatic test_random();
        int p0, t0, n0, g0, p1, t1, n1, g1, chg;
        for (int it = 0; it < 6; it++) begin
            p0 = $urandom_range(2, 40); t0 = $urandom_range(1, p0 + 3);
            n0 = $urandom_range(1, 4);  g0 = $urandom_range(0, 8);
            p1 = $urandom_range(2, 40); t1 = $urandom_range(1, p1 + 3);
            n1 = $urandom_range(1, 4);  g1 = $urandom_range(0, 8);
            chg = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 60)) : -1;
            run_scenario($sformatf("random_%0d", it), 150, p0, t0, n0, g0, chg, p1, t1, n1, g1);
        end
    endtask

    initial begin
        test_reset();
        test_spec_pattern();
        test_clamp();
        test_cfg_update();
        test_same_edge_load();
        test_enable_drop_on();
        test_enable_drop_pre();
        test_invalid();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
